// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - synchroniser, shared-tick debouncer, rise/irq/switch-change pulses
module board_input_conditioner #(
    parameter int SW_WIDTH     = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_TICKS = 4,
    parameter int IRQ_LEN      = 8
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                btn_i,
    input  logic [SW_WIDTH-1:0] sw_i,
    output logic                btn_o,
    output logic                btn_rise_o,
    output logic                irq_o,
    output logic [SW_WIDTH-1:0] sw_o,
    output logic                sw_changed_o
);

    // Channel 0 is the button, channels 1..SW_WIDTH are the switches.
    localparam int N     = SW_WIDTH + 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int IRQ_W = $clog2(IRQ_LEN + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [IRQ_W-1:0] IRQ_LOAD = IRQ_W'(IRQ_LEN);

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     s;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [N-1:0]     level_q;
    logic [N-1:0]     level_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic             rise_q;
    logic             rise_d;
    logic             changed_q;
    logic             changed_d;
    logic [IRQ_W-1:0] irq_cnt_q;

    // Synchroniser chain for all channels; only the last stage feeds the debouncer.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {sw_i, btn_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Free-running sample-tick divider shared by every channel.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign tick = (div_q == DIV_LAST);

    // Per-channel acceptance: a mismatch must persist over STABLE_TICKS ticks,
    // and any cycle back at the stable level throws away the partial count.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = s[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge detection is taken from the next-state so pulses line up with the level change.
    assign rise_d    = level_d[0] & ~level_q[0];
    assign changed_d = (level_d[N-1:1] != level_q[N-1:1]);

    // Stable levels, counters and pulse registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            level_q   <= '0;
            rise_q    <= 1'b0;
            changed_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q   <= level_d;
            rise_q    <= rise_d;
            changed_q <= changed_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // IRQ stretcher: loaded with the rise pulse, so a re-press during the stretch just extends it.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            irq_cnt_q <= '0;
        end else if (rise_d) begin
            irq_cnt_q <= IRQ_LOAD;
        end else if (irq_cnt_q != '0) begin
            irq_cnt_q <= irq_cnt_q - IRQ_W'(1);
        end
    end

    assign btn_o        = level_q[0];
    assign sw_o         = level_q[N-1:1];
    assign btn_rise_o   = rise_q;
    assign sw_changed_o = changed_q;
    assign irq_o        = (irq_cnt_q != '0);

endmodule

// File: tb/tb_board_input_conditioner.sv
// tb/tb_board_input_conditioner.sv - directed table and sequence bench for board_input_conditioner
module tb_board_input_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic [15:0] sw;
    logic        btn_o, rise_o, irq_o, chg_o;
    logic [15:0] sw_o;

    logic        btn2;
    logic [3:0]  sw2;
    logic        btn2_o, rise2_o, irq2_o, chg2_o;
    logic [3:0]  sw2_o;

    int errors = 0;
    int checks = 0;

    int rise_cnt = 0, irq_cnt = 0, chg_cnt = 0;
    int rise2_cnt = 0, irq2_cnt = 0, irq2_runs = 0;
    logic irq2_prev = 1'b0;

    always #5 clk = ~clk;

    board_input_conditioner #(
        .SW_WIDTH(16), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_TICKS(3), .IRQ_LEN(5)
    ) dut (
        .clk_i(clk), .arst_i(rst), .btn_i(btn), .sw_i(sw),
        .btn_o(btn_o), .btn_rise_o(rise_o), .irq_o(irq_o),
        .sw_o(sw_o), .sw_changed_o(chg_o)
    );

    // Fast instance: one tick per cycle, single-tick acceptance, so re-press fits in the stretch.
    board_input_conditioner #(
        .SW_WIDTH(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(1), .IRQ_LEN(5)
    ) dut2 (
        .clk_i(clk), .arst_i(rst), .btn_i(btn2), .sw_i(sw2),
        .btn_o(btn2_o), .btn_rise_o(rise2_o), .irq_o(irq2_o),
        .sw_o(sw2_o), .sw_changed_o(chg2_o)
    );

    // Pulse and level-cycle counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            rise_cnt  <= rise_cnt + int'(rise_o);
            irq_cnt   <= irq_cnt + int'(irq_o);
            chg_cnt   <= chg_cnt + int'(chg_o);
            rise2_cnt <= rise2_cnt + int'(rise2_o);
            irq2_cnt  <= irq2_cnt + int'(irq2_o);
            irq2_runs <= irq2_runs + int'(irq2_o & ~irq2_prev);
            irq2_prev <= irq2_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no summary expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_btn(input logic val, input int limit, output int n);
        n = 0;
        while (btn_o !== val && n < limit) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        logic [15:0] sw_in;
        int          hold;
        logic [15:0] exp_sw;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n, m, r0, i0, c0;

        vecs[0] = '{16'h00A5, 20, 16'h00A5, 1};
        vecs[1] = '{16'h00A5, 20, 16'h00A5, 0};
        vecs[2] = '{16'hFFFF, 20, 16'hFFFF, 1};
        vecs[3] = '{16'h1234,  3, 16'hFFFF, 0};
        vecs[4] = '{16'hFFFF, 20, 16'hFFFF, 0};
        vecs[5] = '{16'h0000, 20, 16'h0000, 1};
        vecs[6] = '{16'h8001, 20, 16'h8001, 1};

        rst = 1'b1; btn = 1'b0; sw = 16'h0; btn2 = 1'b0; sw2 = 4'h0;
        repeat (3) step();
        check("reset_btn_o", 32'(btn_o), 0);
        check("reset_rise", 32'(rise_o), 0);
        check("reset_irq", 32'(irq_o), 0);
        check("reset_sw_o", 32'(sw_o), 0);
        check("reset_chg", 32'(chg_o), 0);
        rst = 1'b0;
        repeat (10) step();
        check("idle_btn_o", 32'(btn_o), 0);
        check("idle_sw2_o", 32'(sw2_o), 0);

        // Switch table, includes 0000 -> 00A5 and a short glitch.
        for (int k = 0; k < 7; k++) begin
            c0 = chg_cnt; r0 = rise_cnt;
            sw = vecs[k].sw_in;
            repeat (vecs[k].hold) step();
            check($sformatf("vec%0d_sw_o", k), 32'(sw_o), 32'(vecs[k].exp_sw));
            check($sformatf("vec%0d_pulses", k), chg_cnt - c0, vecs[k].exp_pulses);
            check($sformatf("vec%0d_btn_o", k), 32'(btn_o), 0);
            check($sformatf("vec%0d_rise", k), rise_cnt - r0, 0);
        end

        // Glitch on the button shorter than the acceptance window.
        r0 = rise_cnt; i0 = irq_cnt;
        btn = 1'b1;
        repeat (5) step();
        btn = 1'b0;
        repeat (20) step();
        check("glitch_btn_o", 32'(btn_o), 0);
        check("glitch_rise", rise_cnt - r0, 0);
        check("glitch_irq", irq_cnt - i0, 0);
        check("glitch_cnt", 32'(dut.cnt_q[0]), 0);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold high.
        r0 = rise_cnt; i0 = irq_cnt;
        for (int k = 0; k < 10; k++) begin
            btn = ~btn;
            repeat (3) step();
        end
        btn = 1'b1;
        wait_btn(1'b1, 40, n);
        check("bounce_latency_ok", 32'(n >= 11 && n <= 14), 1);
        repeat (10) step();
        check("bounce_btn_o", 32'(btn_o), 1);
        check("bounce_rise", rise_cnt - r0, 1);
        check("bounce_irq_len", irq_cnt - i0, 5);

        // Release: falling edge gives no pulse and no irq; then re-press.
        r0 = rise_cnt; i0 = irq_cnt;
        btn = 1'b0;
        wait_btn(1'b0, 40, n);
        check("release_latency_ok", 32'(n >= 11 && n <= 14), 1);
        repeat (5) step();
        check("release_rise", rise_cnt - r0, 0);
        check("release_irq", irq_cnt - i0, 0);
        btn = 1'b1;
        wait_btn(1'b1, 40, n);
        check("repress_latency_ok", 32'(n >= 11 && n <= 14), 1);
        repeat (10) step();
        check("repress_rise", rise_cnt - r0, 1);
        check("repress_irq", irq_cnt - i0, 5);

        // Re-press inside the stretch on the fast instance: one run of 5+2 cycles.
        r0 = rise2_cnt; i0 = irq2_cnt; c0 = irq2_runs;
        btn2 = 1'b1; step();
        btn2 = 1'b0; step();
        btn2 = 1'b1;
        repeat (15) step();
        check("reload_rise", rise2_cnt - r0, 2);
        check("reload_irq_cycles", irq2_cnt - i0, 7);
        check("reload_irq_runs", irq2_runs - c0, 1);
        check("reload_btn2_o", 32'(btn2_o), 1);
        btn2 = 1'b0;

        // Reset mid-count: async clear, then full latency from release.
        btn = 1'b0;
        repeat (20) step();
        check("pre_reset_btn_o", 32'(btn_o), 0);
        btn = 1'b1;
        repeat (8) step();
        #2 rst = 1'b1;
        #1;
        check("arst_sw_o", 32'(sw_o), 0);
        check("arst_btn_o", 32'(btn_o), 0);
        check("arst_irq", 32'(irq_o), 0);
        check("arst_cnt", 32'(dut.cnt_q[0]), 0);
        repeat (3) step();
        rst = 1'b0;
        wait_btn(1'b1, 40, n);
        check("post_reset_latency", n, 12);

        // Staggered switches: two ticks apart give two pulses.
        sw = 16'h0000;
        repeat (20) step();
        c0 = chg_cnt;
        sw = 16'h0001;
        repeat (8) step();
        sw = 16'h8001;
        n = 0;
        while (sw_o[0] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("stagger_first", 32'(sw_o), 32'h0001);
        m = 0;
        while (sw_o !== 16'h8001 && m < 30) begin
            step();
            m++;
        end
        check("stagger_gap", m, 8);
        repeat (5) step();
        check("stagger_pulses", chg_cnt - c0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
